// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register feeding a zero-latency ROM, with a
// 2-entry {instruction, pc} FIFO toward the consumer and redirect support.
module fetch_unit #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [2*DATA_BITS-1:0] rom_data,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [ADDR_BITS-1:0]   redirect_addr,
    output logic [2*DATA_BITS-1:0] instr,
    output logic [ADDR_BITS-1:0]   instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam int IW = 2 * DATA_BITS;

    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [1:0]           count_q, count_d;
    logic [IW-1:0]        head_instr_q, head_instr_d;
    logic [ADDR_BITS-1:0] head_pc_q, head_pc_d;
    logic [IW-1:0]        tail_instr_q, tail_instr_d;
    logic [ADDR_BITS-1:0] tail_pc_q, tail_pc_d;
    logic                 pop;
    logic                 push;

    assign rom_addr    = pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_valid ? head_instr_q : '0;
    assign instr_pc    = instr_valid ? head_pc_q : '0;

    // Head is always the oldest entry; a pop shifts tail into head.
    always_comb begin
        pc_d         = pc_q;
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;

        pop  = instr_valid && instr_ready;
        push = fetch_en && !redirect_valid && ((count_q != 2'd2) || pop);

        if (redirect_valid) begin
            count_d = 2'd0;
            pc_d    = redirect_addr;
        end else begin
            if (push) begin
                pc_d = pc_q + ADDR_BITS'(1);
            end
            case ({push, pop})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        head_instr_d = rom_data;
                        head_pc_d    = pc_q;
                    end else begin
                        tail_instr_d = rom_data;
                        tail_pc_d    = pc_q;
                    end
                end
                2'b01: begin
                    count_d      = count_q - 2'd1;
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_instr_d = rom_data;
                        head_pc_d    = pc_q;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = rom_data;
                        tail_pc_d    = pc_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM holds 16'hA000+addr, outputs are
// checked on the falling edge, inputs change right after the checks.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    assign rom_data = 16'hA000 + {8'h00, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // exp_pc is ignored for instr/instr_pc when exp_valid is 0 (both must read 0)
    task automatic checkOutput(input string tag, input logic exp_valid, input logic [7:0] exp_pc);
        logic [15:0] exp_instr;
        logic [7:0]  exp_ipc;
        exp_instr = exp_valid ? (16'hA000 + {8'h00, exp_pc}) : 16'h0000;
        exp_ipc   = exp_valid ? exp_pc : 8'h00;
        checkValue({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
        checkValue({tag, ".pc"}, {24'd0, instr_pc}, {24'd0, exp_ipc});
        checkValue({tag, ".instr"}, {16'd0, instr}, {16'd0, exp_instr});
    endtask

    task automatic checkRom(input string tag, input logic [7:0] exp_addr);
        checkValue({tag, ".rom_addr"}, {24'd0, rom_addr}, {24'd0, exp_addr});
    endtask

    task automatic applyStimulus(input logic rst, input logic fe, input logic rv,
                                 input logic [7:0] ra, input logic rdy);
        rst_n          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_addr  = ra;
        instr_ready    = rdy;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        step();
        checkOutput("reset", 1'b0, 8'h00);
        checkRom("reset", 8'h00);

        // streaming after reset: one instruction per cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("stream%0d", i), 1'b1, 8'(i));
        end
        checkRom("stream_end", 8'h04);

        // async reset between edges, then back-pressure for 5 cycles
        #2;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("async_rst1", 1'b0, 8'h00);
        checkRom("async_rst1", 8'h00);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        checkOutput("stall_first", 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step();
        checkOutput("stall_hold", 1'b1, 8'h00);
        checkRom("stall_full", 8'h02);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step();
            checkOutput($sformatf("drain%0d", i), 1'b1, 8'(i));
        end

        // redirect near the top of the address space wraps to 0
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE, 1'b1);
        step();
        checkOutput("redir_fe_bubble", 1'b0, 8'h00);
        checkRom("redir_fe", 8'hFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("wrap_fe", 1'b1, 8'hFE);
        step();
        checkOutput("wrap_ff", 1'b1, 8'hFF);
        step();
        checkOutput("wrap_00", 1'b1, 8'h00);
        step();
        checkOutput("wrap_01", 1'b1, 8'h01);

        // fill with 5,6 then redirect to 40 while ready is high
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        step();
        checkOutput("full56", 1'b1, 8'h05);
        checkRom("full56", 8'h07);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
        step();
        checkOutput("redir40_bubble", 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("redir40", 1'b1, 8'h40);
        step();
        checkOutput("redir41", 1'b1, 8'h41);

        // fetch_en low drains the buffer and freezes the PC
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        checkOutput("fill41", 1'b1, 8'h41);
        checkRom("fill41", 8'h43);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("fe0_drain42", 1'b1, 8'h42);
        checkRom("fe0_drain42", 8'h43);
        step();
        checkOutput("fe0_empty", 1'b0, 8'h00);
        step();
        checkOutput("fe0_idle", 1'b0, 8'h00);
        checkRom("fe0_idle", 8'h43);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("fe1_resume", 1'b1, 8'h43);

        // async reset with a full buffer and a concurrent redirect
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        checkOutput("full43", 1'b1, 8'h43);
        #2;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h80, 1'b1);
        #1;
        checkOutput("async_rst2", 1'b0, 8'h00);
        checkRom("async_rst2", 8'h00);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("rst_held", 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step();
        checkOutput("restart0", 1'b1, 8'h00);
        step();
        checkOutput("restart1", 1'b1, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
